shift_register_universal: RTL and testbench

Parametrised universal shift register: the successor of the team's fixed single-bit SISO register. It supports:
- configurable `WIDTH`;
- hold, shift-right, shift-left and parallel-load modes;
- optional rotation;
- a serial-out tap;
- a shift counter with a one-cycle frame-complete pulse.

It sits between serial links and parallel datapaths as a SISO/SIPO/PISO/PIPO building block.

---
 rtl/shift_register_universal_pkg.sv | 18 +
 rtl/shift_register_universal_if.sv | 32 +++
 rtl/shift_register_universal_frame_counter.sv | 44 ++++
 rtl/shift_register_universal.sv | 73 +++++++
 tb/tb_shift_register_universal.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/shift_register_universal_pkg.sv
// rtl/shift_register_universal_pkg.sv - shared types and helpers for the universal shift register
// Contents:
//   shift_mode_e : 2-bit operation select (HOLD / SHR / SHL / LOAD), fully decoded
//   cnt_w()      : width of the shift counter for a given register width
package shift_pkg;

  typedef enum logic [1:0] {
    SM_HOLD = 2'b00,
    SM_SHR  = 2'b01,
    SM_SHL  = 2'b10,
    SM_LOAD = 2'b11
  } shift_mode_e;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shift_register_universal_if.sv
// rtl/shift_register_universal_if.sv - control/data bundle for the universal shift register
// Signals:
//   en, mode, rot, D, P     : driven by the controlling side (master)
//   Q, SO, cnt, frame_done  : driven by the shift register (slave)
interface shift_register_universal_if #(
  parameter int WIDTH = 8
);
  import shift_pkg::*;

  localparam int CW = cnt_w(WIDTH);

  logic             en;
  shift_mode_e      mode;
  logic             rot;
  logic             D;
  logic [WIDTH-1:0] P;
  logic [WIDTH-1:0] Q;
  logic             SO;
  logic [CW-1:0]    cnt;
  logic             frame_done;

  modport master (
    output en, mode, rot, D, P,
    input  Q, SO, cnt, frame_done
  );

  modport slave (
    input  en, mode, rot, D, P,
    output Q, SO, cnt, frame_done
  );

endinterface

// File: rtl/shift_register_universal_frame_counter.sv
// rtl/shift_register_universal_frame_counter.sv - modulo-WIDTH shift counter with registered wrap pulse
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   inc      : count one shift this edge
//   clr      : restart the frame (takes priority over inc)
//   cnt      : shifts counted in the current frame, 0..WIDTH-1
//   wrap     : high for the one cycle after the edge that completed a frame
module shift_frame_counter
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc,
  input  logic                    clr,
  output logic [cnt_w(WIDTH)-1:0] cnt,
  output logic                    wrap
);

  localparam int            CW      = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      // wrap is a pulse: any edge that does not complete a frame drops it
      wrap <= 1'b0;
      if (clr) begin
        cnt <= '0;
      end else if (inc) begin
        if (cnt == CNT_MAX) begin
          cnt  <= '0;
          wrap <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/shift_register_universal.sv
// rtl/shift_register_universal.sv - parametrised universal shift register (SISO/SIPO/PISO/PIPO)
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of shift_register_universal_if
//          en/mode/rot/D/P in; Q (contents), SO (serial tap), cnt, frame_done out
module shift_register_universal
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  shift_register_universal_if.slave  bus
);

  localparam int CW = cnt_w(WIDTH);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic             fill_r;
  logic             fill_l;
  logic             is_shift;
  logic             cnt_inc;
  logic             cnt_clr;
  logic [CW-1:0]    cnt_w_s;
  logic             wrap_s;

  // In rotate mode the bit leaving one end re-enters at the other and D is ignored
  assign fill_r = bus.rot ? q_r[0]       : bus.D;
  assign fill_l = bus.rot ? q_r[WIDTH-1] : bus.D;

  always_comb begin
    q_nxt = q_r;
    case (bus.mode)
      SM_SHR:  q_nxt = {fill_r, q_r[WIDTH-1:1]};
      SM_SHL:  q_nxt = {q_r[WIDTH-2:0], fill_l};
      SM_LOAD: q_nxt = bus.P;
      default: q_nxt = q_r;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= '0;
    end else if (bus.en) begin
      q_r <= q_nxt;
    end
  end

  // Counting is direction-agnostic and independent of rot
  assign is_shift = (bus.mode == SM_SHR) || (bus.mode == SM_SHL);
  assign cnt_inc  = bus.en && is_shift;
  assign cnt_clr  = bus.en && (bus.mode == SM_LOAD);

  shift_frame_counter #(
    .WIDTH (WIDTH)
  ) u_frame_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (cnt_inc),
    .clr  (cnt_clr),
    .cnt  (cnt_w_s),
    .wrap (wrap_s)
  );

  assign bus.Q          = q_r;
  // SO is the bit that the current mode's next edge pushes out
  assign bus.SO         = (bus.mode == SM_SHL) ? q_r[WIDTH-1] : q_r[0];
  assign bus.cnt        = cnt_w_s;
  assign bus.frame_done = wrap_s;

endmodule

// File: tb/tb_shift_register_universal.sv
// tb/tb_shift_register_universal.sv - directed table-driven bench for shift_register_universal (WIDTH=4)
module tb_shift_register_universal;
  import shift_pkg::*;

  localparam int W = 4;

  typedef struct {
    logic        en;
    shift_mode_e mode;
    logic        rot;
    logic        d;
    logic [3:0]  p;
    logic        exp_so;
    logic [3:0]  exp_q;
    logic [1:0]  exp_cnt;
    logic        exp_fd;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  shift_register_universal_if #(.WIDTH(W)) bus ();

  shift_register_universal #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t hand[$];
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Inputs change at negedge; SO checked just after, state checked 1ns after the posedge
  task automatic apply(input vec_t v, input string tag, input int idx);
    @(negedge clk);
    bus.en   = v.en;
    bus.mode = v.mode;
    bus.rot  = v.rot;
    bus.D    = v.d;
    bus.P    = v.p;
    #1;
    chk($sformatf("%s[%0d].SO", tag, idx), 64'(bus.SO), 64'(v.exp_so));
    @(posedge clk);
    #1;
    chk($sformatf("%s[%0d].Q", tag, idx),   64'(bus.Q),          64'(v.exp_q));
    chk($sformatf("%s[%0d].cnt", tag, idx), 64'(bus.cnt),        64'(v.exp_cnt));
    chk($sformatf("%s[%0d].fd", tag, idx),  64'(bus.frame_done), 64'(v.exp_fd));
  endtask

  initial begin
    //            en    mode     rot   d     p        so    q        cnt    fd
    // Hand sequence: load, rotate a full frame, then reset while frame_done is high
    hand.push_back('{1'b1, SM_LOAD, 1'b0, 1'b0, 4'b1010, 1'b0, 4'b1010, 2'd0, 1'b0});
    hand.push_back('{1'b1, SM_SHR,  1'b1, 1'b1, 4'b0000, 1'b0, 4'b0101, 2'd1, 1'b0});
    hand.push_back('{1'b1, SM_SHR,  1'b1, 1'b0, 4'b0000, 1'b1, 4'b1010, 2'd2, 1'b0});
    hand.push_back('{1'b1, SM_SHR,  1'b1, 1'b1, 4'b0000, 1'b0, 4'b0101, 2'd3, 1'b0});
    hand.push_back('{1'b1, SM_SHR,  1'b1, 1'b0, 4'b0000, 1'b1, 4'b1010, 2'd0, 1'b1});

    // SISO right shift
    vecs.push_back('{1'b1, SM_SHR,  1'b0, 1'b1, 4'b0000, 1'b0, 4'b1000, 2'd1, 1'b0});
    vecs.push_back('{1'b1, SM_SHR,  1'b0, 1'b1, 4'b0000, 1'b0, 4'b1100, 2'd2, 1'b0});
    vecs.push_back('{1'b1, SM_SHR,  1'b0, 1'b0, 4'b0000, 1'b0, 4'b0110, 2'd3, 1'b0});
    vecs.push_back('{1'b1, SM_SHR,  1'b0, 1'b1, 4'b0000, 1'b0, 4'b1011, 2'd0, 1'b1});
    vecs.push_back('{1'b1, SM_HOLD, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b1011, 2'd0, 1'b0});
    // PISO left shift
    vecs.push_back('{1'b1, SM_LOAD, 1'b0, 1'b0, 4'b1101, 1'b1, 4'b1101, 2'd0, 1'b0});
    vecs.push_back('{1'b1, SM_SHL,  1'b0, 1'b0, 4'b0000, 1'b1, 4'b1010, 2'd1, 1'b0});
    vecs.push_back('{1'b1, SM_SHL,  1'b0, 1'b0, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0});
    vecs.push_back('{1'b1, SM_SHL,  1'b0, 1'b0, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b0});
    vecs.push_back('{1'b1, SM_SHL,  1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b1});
    // Rotate left, D toggling ignored
    vecs.push_back('{1'b1, SM_LOAD, 1'b0, 1'b0, 4'b1001, 1'b0, 4'b1001, 2'd0, 1'b0});
    vecs.push_back('{1'b1, SM_SHL,  1'b1, 1'b1, 4'b0000, 1'b1, 4'b0011, 2'd1, 1'b0});
    vecs.push_back('{1'b1, SM_SHL,  1'b1, 1'b0, 4'b0000, 1'b0, 4'b0110, 2'd2, 1'b0});
    vecs.push_back('{1'b1, SM_SHL,  1'b1, 1'b1, 4'b0000, 1'b0, 4'b1100, 2'd3, 1'b0});
    vecs.push_back('{1'b1, SM_SHL,  1'b1, 1'b0, 4'b0000, 1'b1, 4'b1001, 2'd0, 1'b1});
    // Enable, hold and mixed direction
    vecs.push_back('{1'b1, SM_SHR,  1'b0, 1'b0, 4'b0000, 1'b1, 4'b0100, 2'd1, 1'b0});
    vecs.push_back('{1'b1, SM_SHR,  1'b0, 1'b1, 4'b0000, 1'b0, 4'b1010, 2'd2, 1'b0});
    vecs.push_back('{1'b0, SM_SHR,  1'b0, 1'b1, 4'b1111, 1'b0, 4'b1010, 2'd2, 1'b0});
    vecs.push_back('{1'b0, SM_SHL,  1'b0, 1'b1, 4'b1111, 1'b1, 4'b1010, 2'd2, 1'b0});
    vecs.push_back('{1'b0, SM_LOAD, 1'b0, 1'b1, 4'b1111, 1'b0, 4'b1010, 2'd2, 1'b0});
    vecs.push_back('{1'b1, SM_HOLD, 1'b0, 1'b1, 4'b1111, 1'b0, 4'b1010, 2'd2, 1'b0});
    vecs.push_back('{1'b1, SM_SHL,  1'b0, 1'b1, 4'b0000, 1'b1, 4'b0101, 2'd3, 1'b0});
    vecs.push_back('{1'b1, SM_SHL,  1'b0, 1'b0, 4'b0000, 1'b0, 4'b1010, 2'd0, 1'b1});
    vecs.push_back('{1'b1, SM_HOLD, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b1010, 2'd0, 1'b0});
    // LOAD mid-frame, then a clean frame and a back-to-back frame
    vecs.push_back('{1'b1, SM_SHR,  1'b1, 1'b1, 4'b0000, 1'b0, 4'b0101, 2'd1, 1'b0});
    vecs.push_back('{1'b1, SM_SHR,  1'b1, 1'b0, 4'b0000, 1'b1, 4'b1010, 2'd2, 1'b0});
    vecs.push_back('{1'b1, SM_SHR,  1'b1, 1'b1, 4'b0000, 1'b0, 4'b0101, 2'd3, 1'b0});
    vecs.push_back('{1'b1, SM_LOAD, 1'b0, 1'b0, 4'b0110, 1'b1, 4'b0110, 2'd0, 1'b0});
    vecs.push_back('{1'b1, SM_SHR,  1'b0, 1'b0, 4'b0000, 1'b0, 4'b0011, 2'd1, 1'b0});
    vecs.push_back('{1'b1, SM_SHR,  1'b0, 1'b0, 4'b0000, 1'b1, 4'b0001, 2'd2, 1'b0});
    vecs.push_back('{1'b1, SM_SHR,  1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0});
    vecs.push_back('{1'b1, SM_SHR,  1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1});
    vecs.push_back('{1'b1, SM_SHL,  1'b0, 1'b1, 4'b0000, 1'b0, 4'b0001, 2'd1, 1'b0});
    vecs.push_back('{1'b1, SM_SHL,  1'b0, 1'b1, 4'b0000, 1'b0, 4'b0011, 2'd2, 1'b0});
    vecs.push_back('{1'b1, SM_SHL,  1'b0, 1'b1, 4'b0000, 1'b0, 4'b0111, 2'd3, 1'b0});
    vecs.push_back('{1'b1, SM_SHL,  1'b0, 1'b1, 4'b0000, 1'b0, 4'b1111, 2'd0, 1'b1});
    vecs.push_back('{1'b1, SM_HOLD, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b1111, 2'd0, 1'b0});

    // Reset state
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.mode = SM_HOLD;
    bus.rot  = 1'b0;
    bus.D    = 1'b0;
    bus.P    = '0;
    @(negedge clk);
    chk("reset.Q",   64'(bus.Q),          64'(0));
    chk("reset.cnt", 64'(bus.cnt),        64'(0));
    chk("reset.fd",  64'(bus.frame_done), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < hand.size(); i++) apply(hand[i], "pre", i);

    // Asynchronous reset between edges, with Q nonzero and frame_done high
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst.Q",   64'(bus.Q),          64'(0));
    chk("async_rst.cnt", 64'(bus.cnt),        64'(0));
    chk("async_rst.fd",  64'(bus.frame_done), 64'(0));
    @(negedge clk);
    bus.en   = 1'b1;
    bus.mode = SM_HOLD;
    rst      = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], "vec", i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
